// File: rtl/kbd_codes_pkg.sv
// Scan-code set 2 constants and decoder state encoding
// shared by the keyboard event decoder files.
package kbd_codes_pkg;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_P     = 8'h4D;
  localparam logic [7:0] CODE_ACK   = 8'hFA;
  localparam logic [7:0] CODE_BAT   = 8'hAA;
  localparam logic [7:0] CODE_ECHO  = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  // Keyboard housekeeping replies, never part of a key sequence
  function automatic logic is_ignored(input logic [7:0] c);
    return (c == CODE_ACK) || (c == CODE_BAT) || (c == CODE_ECHO);
  endfunction

endpackage

// File: rtl/key_edge_latch.sv
// Held flag for one key; flags the first make and
// suppresses typematic repeats until the matching break.
module key_edge_latch (
  input  logic CLK,
  input  logic RESET,
  input  logic make,
  input  logic brk,
  output logic first
);

  logic held;

  assign first = make & ~held;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      held <= 1'b0;
    else if (make)
      held <= 1'b1;
    else if (brk)
      held <= 1'b0;
  end

endmodule

// File: rtl/key_event_decoder.sv
// Parses PS/2 set 2 byte sequences into game-control
// key levels and pulses, with prefix timeout recovery.
module key_event_decoder
  import kbd_codes_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 1000000,
  parameter int TMO_W          = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] CODEWORD,
  output logic       KEY_LEFT,
  output logic       KEY_RIGHT,
  output logic       FIRE_PULSE,
  output logic       START_PULSE,
  output logic       PAUSE,
  output logic       SEQ_ERR
);

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(PREFIX_TIMEOUT - 1);

  kbd_state_e       state, state_n;
  logic [TMO_W-1:0] cnt;
  logic             acc, tmo;
  logic             mk, bk, ext;

  assign acc = (CODEWORD != 8'h00) && !is_ignored(CODEWORD);
  assign tmo = (state != ST_IDLE) && !acc && (cnt == TMO_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (acc || tmo)
        cnt <= '0;
      else if (state != ST_IDLE && cnt != TMO_LAST)
        cnt <= cnt + 1'b1;
    end
  end

  // A prefix arriving after F0 restarts the sequence
  always_comb begin
    state_n = state;
    mk      = 1'b0;
    bk      = 1'b0;
    ext     = 1'b0;
    if (acc) begin
      unique case (1'b1)
        CODEWORD == CODE_EXT:
          state_n = ST_EXT;
        CODEWORD == CODE_BRK:
          state_n = (state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
        default: begin
          state_n = ST_IDLE;
          ext = (state == ST_EXT) || (state == ST_EXT_BRK);
          mk  = (state == ST_IDLE) || (state == ST_EXT);
          bk  = !mk;
        end
      endcase
    end else if (tmo) begin
      state_n = ST_IDLE;
    end
  end

  logic s_mk, s_bk, s_first;
  logic e_mk, e_bk, e_first;
  logic p_mk, p_bk, p_first;
  logic l_hit, r_hit;

  assign s_mk  = mk & ~ext & (CODEWORD == CODE_SPACE);
  assign s_bk  = bk & ~ext & (CODEWORD == CODE_SPACE);
  assign e_mk  = mk & ~ext & (CODEWORD == CODE_ENTER);
  assign e_bk  = bk & ~ext & (CODEWORD == CODE_ENTER);
  assign p_mk  = mk & ~ext & (CODEWORD == CODE_P);
  assign p_bk  = bk & ~ext & (CODEWORD == CODE_P);
  assign l_hit = ext & (CODEWORD == CODE_LEFT);
  assign r_hit = ext & (CODEWORD == CODE_RIGHT);

  key_edge_latch u_space (
    .CLK(CLK), .RESET(RESET),
    .make(s_mk), .brk(s_bk), .first(s_first)
  );

  key_edge_latch u_enter (
    .CLK(CLK), .RESET(RESET),
    .make(e_mk), .brk(e_bk), .first(e_first)
  );

  key_edge_latch u_p (
    .CLK(CLK), .RESET(RESET),
    .make(p_mk), .brk(p_bk), .first(p_first)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      KEY_LEFT    <= 1'b0;
      KEY_RIGHT   <= 1'b0;
      FIRE_PULSE  <= 1'b0;
      START_PULSE <= 1'b0;
      PAUSE       <= 1'b0;
      SEQ_ERR     <= 1'b0;
    end else begin
      if (l_hit) KEY_LEFT  <= mk;
      if (r_hit) KEY_RIGHT <= mk;
      FIRE_PULSE  <= s_first;
      START_PULSE <= e_first;
      if (p_first) PAUSE <= ~PAUSE;
      SEQ_ERR     <= tmo;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized self-checking bench for key_event_decoder
// against a sequence-level behavioural model.
module tb_key_event_decoder;

  localparam int TMO = 16;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] CODEWORD = 8'h00;
  logic       KEY_LEFT, KEY_RIGHT, FIRE_PULSE;
  logic       START_PULSE, PAUSE, SEQ_ERR;

  int errors = 0;
  int checks = 0;

  key_event_decoder #(.PREFIX_TIMEOUT(TMO), .TMO_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .CODEWORD(CODEWORD),
    .KEY_LEFT(KEY_LEFT), .KEY_RIGHT(KEY_RIGHT),
    .FIRE_PULSE(FIRE_PULSE), .START_PULSE(START_PULSE),
    .PAUSE(PAUSE), .SEQ_ERR(SEQ_ERR)
  );

  always #5 CLK = ~CLK;

  logic [5:0] obs;
  assign obs = {KEY_LEFT, KEY_RIGHT, FIRE_PULSE,
                START_PULSE, PAUSE, SEQ_ERR};

  // Model: pending prefixes, quiet cycles, key facts
  bit m_ext, m_brk;
  int m_quiet;
  bit m_left, m_right, m_pause;
  bit m_fire, m_start, m_seqerr;
  bit m_held [3];

  function automatic logic [5:0] exp_vec();
    return {m_left, m_right, m_fire, m_start, m_pause, m_seqerr};
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_quiet = 0;
    m_left = 0; m_right = 0; m_pause = 0;
    m_fire = 0; m_start = 0; m_seqerr = 0;
    for (int i = 0; i < 3; i++) m_held[i] = 0;
  endtask

  task automatic model_key(input logic [7:0] b);
    int idx;
    if (m_ext) begin
      if (b == 8'h6B) m_left = !m_brk;
      if (b == 8'h74) m_right = !m_brk;
    end else begin
      idx = (b == 8'h29) ? 0 : (b == 8'h5A) ? 1 :
            (b == 8'h4D) ? 2 : -1;
      if (idx >= 0) begin
        if (m_brk) m_held[idx] = 0;
        else if (!m_held[idx]) begin
          m_held[idx] = 1;
          if (idx == 0) m_fire = 1;
          if (idx == 1) m_start = 1;
          if (idx == 2) m_pause = !m_pause;
        end
      end
    end
  endtask

  task automatic model_step(input logic [7:0] b);
    bit acc;
    m_fire = 0; m_start = 0; m_seqerr = 0;
    acc = (b != 8'h00) && b != 8'hFA && b != 8'hAA && b != 8'hEE;
    if (acc) begin
      m_quiet = 0;
      if (b == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        if (m_brk) m_ext = 0;
        m_brk = 1;
      end else begin
        model_key(b);
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_quiet++;
      if (m_quiet == TMO) begin
        m_ext = 0; m_brk = 0; m_quiet = 0; m_seqerr = 1;
      end
    end
  endtask

  task automatic step(input logic [7:0] b);
    @(negedge CLK);
    CODEWORD = b;
    @(posedge CLK);
    #1;
    CODEWORD = 8'h00;
    model_step(b);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset got=%b exp=000000", obs);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_fire();
    logic [7:0] seq [4] = '{8'h29, 8'h00, 8'hF0, 8'h29};
    int fires = 0;
    for (int i = 0; i < 4; i++) begin
      step(seq[i]);
      fires += int'(FIRE_PULSE);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL fire i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      if (i == 1) begin
        repeat ($urandom_range(1, 4)) begin
          step(8'h00);
          fires += int'(FIRE_PULSE);
        end
      end
    end
    step(8'h00);
    fires += int'(FIRE_PULSE);
    checks++;
    if (fires !== 1) begin
      errors++;
      $display("FAIL fire_count got=%0d exp=1", fires);
    end
  endtask

  task automatic test_typematic();
    logic [7:0] seq [7] = '{8'h29, 8'h29, 8'h29, 8'hF0,
                            8'h29, 8'h29, 8'h00};
    int fires = 0;
    for (int i = 0; i < 7; i++) begin
      step(seq[i]);
      fires += int'(FIRE_PULSE);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL typematic i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    checks++;
    if (fires !== 2) begin
      errors++;
      $display("FAIL typematic_count got=%0d exp=2", fires);
    end
    step(8'hF0);
    step(8'h29);
  endtask

  task automatic test_arrows();
    logic [7:0] seq [7] = '{8'hE0, 8'h6B, 8'hE0, 8'h74,
                            8'hE0, 8'hF0, 8'h6B};
    for (int i = 0; i < 7; i++) begin
      step(seq[i]);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL arrows i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    checks++;
    if ({KEY_LEFT, KEY_RIGHT} !== 2'b01) begin
      errors++;
      $display("FAIL arrows_final got=%b exp=01", {KEY_LEFT, KEY_RIGHT});
    end
    step(8'hE0);
    step(8'hF0);
    step(8'h74);
  endtask

  task automatic test_timeout();
    int errs = 0;
    step(8'hE0);
    for (int i = 1; i <= TMO; i++) begin
      step(8'h00);
      errs += int'(SEQ_ERR);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL timeout i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    step(8'h6B);
    errs += int'(SEQ_ERR);
    checks++;
    if (errs !== 1 || KEY_LEFT !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after seq_err=%0d left=%b exp=1,0",
               errs, KEY_LEFT);
    end
    step(8'hE0);
    repeat (TMO - 1) step(8'h00);
    step(8'h6B);
    checks++;
    if (obs !== exp_vec() || SEQ_ERR !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge got=%b exp=%b", obs, exp_vec());
    end
    step(8'hE0);
    step(8'hF0);
    step(8'h6B);
  endtask

  task automatic test_pause();
    logic [7:0] seq [9] = '{8'h4D, 8'hF0, 8'h4D, 8'h4D, 8'hE0,
                            8'hFA, 8'h74, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) begin
      step(seq[i]);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL pause i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    checks++;
    if ({KEY_RIGHT, PAUSE} !== 2'b10) begin
      errors++;
      $display("FAIL pause_final got=%b exp=10", {KEY_RIGHT, PAUSE});
    end
  endtask

  task automatic test_reset_mid();
    step(8'hF0);
    step(8'h4D);
    step(8'h4D);
    step(8'hE0);
    step(8'hF0);
    checks++;
    if ({KEY_RIGHT, PAUSE} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_pre got=%b exp=11", {KEY_RIGHT, PAUSE});
    end
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=000000", obs);
    end
    @(negedge CLK);
    RESET = 1'b0;
    step(8'h74);
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_after got=%b exp=%b", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] keys [5] = '{8'h6B, 8'h74, 8'h29, 8'h5A, 8'h4D};
    logic [7:0] junk [3] = '{8'hFA, 8'hAA, 8'hEE};
    logic [7:0] b;
    int r;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        repeat (TMO + 2) begin
          step(8'h00);
          checks++;
          if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL random_gap n=%0d got=%b exp=%b",
                     n, obs, exp_vec());
          end
        end
        continue;
      end
      if (r < 30) b = 8'h00;
      else if (r < 42) b = 8'hE0;
      else if (r < 54) b = 8'hF0;
      else if (r < 84) b = keys[$urandom_range(0, 4)];
      else if (r < 90) b = junk[$urandom_range(0, 2)];
      else b = 8'($urandom_range(1, 255));
      step(b);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random n=%0d byte=%h got=%b exp=%b",
                 n, b, obs, exp_vec());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fire();
    test_typematic();
    test_arrows();
    test_timeout();
    test_pause();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
